// File: rtl/ucaspian_packet_encoder.sv
// Core-to-host response encoder: arbitrates core completion events into byte packets on a
// valid/ready TX byte stream. Define PKT_CHECKSUM_EN to append an XOR checksum byte to every packet.
module ucaspian_packet_encoder #(
  parameter int CFG_PEND_W = 4,
  parameter int TIME_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_done,
  output logic        ack_sent,
  input  logic        config_done,
  input  logic [7:0]  metric_value,
  input  logic        metric_send,
  output logic        metric_done,
  input  logic [7:0]  output_fire_addr,
  input  logic        output_fire_waiting,
  output logic        output_fire_sent,
  input  logic [31:0] time_current,
  input  logic        time_update,
  output logic        time_sent,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy
);

`ifdef PKT_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif
  localparam int PKT_MAX = 1 + TIME_BYTES + CHK_BYTES;
  localparam int IDX_W   = $clog2(PKT_MAX + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [2:0] P_CLEAR  = 3'd0;
  localparam logic [2:0] P_CFG    = 3'd1;
  localparam logic [2:0] P_METRIC = 3'd2;
  localparam logic [2:0] P_FIRE   = 3'd3;
  localparam logic [2:0] P_TIME   = 3'd4;

  localparam logic [7:0] OP_CLEAR  = 8'h01;
  localparam logic [7:0] OP_CFG    = 8'h02;
  localparam logic [7:0] OP_TIME   = 8'h03;
  localparam logic [7:0] OP_METRIC = 8'h04;
  localparam logic [7:0] OP_FIRE   = 8'h05;

  logic [2:0]            state;
  logic [2:0]            pkt_type;
  logic [2:0]            arb_type;
  logic                  req_any;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      pkt_len;
  logic [IDX_W-1:0]      load_len;
  logic [7:0]            pkt_buf    [PKT_MAX];
  logic [7:0]            load_bytes [PKT_MAX];
  logic [CFG_PEND_W-1:0] cfg_pend;
  logic                  cfg_launch;
  logic                  slot_full;
  logic                  m_hold;
  logic                  metric_capture;
  logic [7:0]            metric_byte;
  logic                  last_byte;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]            load_chk;
`endif

  // Fixed-priority arbitration, only acted on in IDLE.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    req_any  = 1'b1;
    arb_type = P_CLEAR;
    if (clear_done)               arb_type = P_CLEAR;
    else if (cfg_pend != '0)      arb_type = P_CFG;
    else if (slot_full)           arb_type = P_METRIC;
    else if (output_fire_waiting) arb_type = P_FIRE;
    else if (time_update)         arb_type = P_TIME;
    else                          req_any  = 1'b0;
  end

  assign cfg_launch     = (state == S_IDLE) && !clear_done && (cfg_pend != '0);
  assign metric_capture = metric_send && !slot_full && !m_hold;
  assign last_byte      = (state == S_SEND) && tx_rdy && (idx == pkt_len - IDX_W'(1));

  // Packet image built from the live payload sources; captured once in LOAD.
  always_comb begin
    for (int i = 0; i < PKT_MAX; i++) load_bytes[i] = '0;
    load_len = IDX_W'(1);
    case (pkt_type)
      P_CLEAR: load_bytes[0] = OP_CLEAR;
      P_CFG:   load_bytes[0] = OP_CFG;
      P_METRIC: begin
        load_bytes[0] = OP_METRIC;
        load_bytes[1] = metric_byte;
        load_len      = IDX_W'(2);
      end
      P_FIRE: begin
        load_bytes[0] = OP_FIRE;
        load_bytes[1] = output_fire_addr;
        load_len      = IDX_W'(2);
      end
      P_TIME: begin
        load_bytes[0] = OP_TIME;
        for (int b = 0; b < TIME_BYTES; b++)
          load_bytes[1+b] = time_current[8*(TIME_BYTES-1-b) +: 8];
        load_len = IDX_W'(1 + TIME_BYTES);
      end
      default: ;
    endcase
`ifdef PKT_CHECKSUM_EN
    // Unused slots are zero, so XOR over the whole image equals XOR over the real bytes.
    load_chk = '0;
    for (int i = 0; i < PKT_MAX; i++) load_chk = load_chk ^ load_bytes[i];
    for (int i = 1; i < PKT_MAX; i++)
      if (IDX_W'(i) == load_len) load_bytes[i] = load_chk;
    load_len = load_len + IDX_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state    <= S_IDLE;
      pkt_type <= P_CLEAR;
      idx      <= '0;
      pkt_len  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_any) begin
          pkt_type <= arb_type;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          pkt_len <= load_len;
          idx     <= '0;
          state   <= S_SEND;
        end
        S_SEND: if (tx_rdy) begin
          if (idx == pkt_len - IDX_W'(1)) state <= S_DONE;
          else                            idx   <= idx + IDX_W'(1);
        end
        S_DONE:  state <= S_GAP;
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the packet buffer has no reset; it is only read in SEND, which always follows a LOAD.
  always_ff @(posedge clk) begin
    if (state == S_LOAD)
      for (int i = 0; i < PKT_MAX; i++) pkt_buf[i] <= load_bytes[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_pend <= '0;
    end else if (config_done && !cfg_launch) begin
      if (cfg_pend != {CFG_PEND_W{1'b1}}) cfg_pend <= cfg_pend + CFG_PEND_W'(1);
    end else if (!config_done && cfg_launch) begin
      cfg_pend <= cfg_pend - CFG_PEND_W'(1);
    end
  end

  // m_hold blocks re-capture of the same level-held metric until metric_send drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_full   <= 1'b0;
      metric_byte <= '0;
      metric_done <= 1'b0;
      m_hold      <= 1'b0;
    end else begin
      metric_done <= metric_capture;
      if (last_byte && pkt_type == P_METRIC) begin
        slot_full <= 1'b0;
      end else if (metric_capture) begin
        slot_full   <= 1'b1;
        metric_byte <= metric_value;
      end
      if (!metric_send)        m_hold <= 1'b0;
      else if (metric_capture) m_hold <= 1'b1;
    end
  end

  assign tx_vld           = (state == S_SEND);
  assign tx_data          = tx_vld ? pkt_buf[idx] : 8'h00;
  assign ack_sent         = (state == S_DONE) && (pkt_type == P_CLEAR);
  assign output_fire_sent = (state == S_DONE) && (pkt_type == P_FIRE);
  assign time_sent        = (state == S_DONE) && (pkt_type == P_TIME);
  assign busy             = (state != S_IDLE) | clear_done | (cfg_pend != '0) | slot_full
                          | output_fire_waiting | time_update;

endmodule

// File: tb/tb_ucaspian_packet_encoder.sv
// Self-checking bench for ucaspian_packet_encoder: vector table, directed corner sequences and a
// randomized run scored by a packet-level model of the host stream.
module tb_ucaspian_packet_encoder;

`ifdef PKT_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int T_ACK  = 256;
  localparam int T_FIRE = 257;
  localparam int T_TIME = 258;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_done, ack_sent, config_done;
  logic [7:0]  metric_value;
  logic        metric_send, metric_done;
  logic [7:0]  output_fire_addr;
  logic        output_fire_waiting, output_fire_sent;
  logic [31:0] time_current;
  logic        time_update, time_sent;
  logic [7:0]  tx_data;
  logic        tx_vld, tx_rdy, busy;

  ucaspian_packet_encoder dut (
    .clk(clk), .reset_n(reset_n),
    .clear_done(clear_done), .ack_sent(ack_sent),
    .config_done(config_done),
    .metric_value(metric_value), .metric_send(metric_send), .metric_done(metric_done),
    .output_fire_addr(output_fire_addr), .output_fire_waiting(output_fire_waiting),
    .output_fire_sent(output_fire_sent),
    .time_current(time_current), .time_update(time_update), .time_sent(time_sent),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   log_q[$];
  int   exp_q[$];
  int   rdy_mode = 0;
  bit   auto_metric = 1'b1;
  int   n_mdone = 0;
  int   stab_err = 0;
  bit   have_held = 1'b0;
  logic [7:0] held_byte = 8'h00;
  int   need = 0;
  int   cfg_seen = 0;

  typedef struct {
    int          kind;     // 0 clear, 1 cfg, 2 metric, 3 fire, 4 time
    logic [31:0] payload;
    int          rdy;      // 0 always, 1 toggle, 2 random
    int          nbytes;
    logic [47:0] bytes;    // expected bytes, MSB first, checksum excluded
    int          pulse;    // expected sent token or -1
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int pkt_len_of(input int op);
    case (op)
      1, 2:    return 1 + CHK;
      4, 5:    return 2 + CHK;
      3:       return 5 + CHK;
      default: return 1;
    endcase
  endfunction

  // One clock: drive tx_rdy, record what the sink accepts this cycle, react like the core.
  task automatic tick();
    case (rdy_mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = ~tx_rdy;
      2:       tx_rdy = ($urandom_range(0, 3) != 0);
      default: tx_rdy = 1'b0;
    endcase
    if (reset_n) begin
      if (have_held && (!tx_vld || tx_data !== held_byte)) stab_err++;
      have_held = tx_vld && !tx_rdy;
      held_byte = tx_data;
      if (tx_vld && tx_rdy) begin
        log_q.push_back(int'(tx_data));
        if (need == 0) begin
          need = pkt_len_of(int'(tx_data)) - 1;
          if (tx_data == 8'h02) cfg_seen++;
        end else begin
          need--;
        end
      end
      if (ack_sent)         begin log_q.push_back(T_ACK);  clear_done = 1'b0; end
      if (output_fire_sent) begin log_q.push_back(T_FIRE); output_fire_waiting = 1'b0; end
      if (time_sent)        begin log_q.push_back(T_TIME); time_update = 1'b0; end
      if (metric_done) begin
        n_mdone++;
        if (auto_metric) metric_send = 1'b0;
      end
    end else begin
      have_held = 1'b0;
      need = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (!busy) break;
    end
    check({name, " reaches idle"}, int'(busy), 0);
  endtask

  task automatic push_pkt(input logic [47:0] b, input int n, input int pulse);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(int'(b[47-8*i -: 8]));
      x = x ^ b[47-8*i -: 8];
    end
    if (CHK != 0) exp_q.push_back(int'(x));
    if (pulse >= 0) exp_q.push_back(pulse);
  endtask

  task automatic compare_log(input string name);
    int n;
    check({name, " token count"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s token%0d", name, i), log_q[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fire_q[$];
    logic [31:0] time_q[$];
    logic [31:0] metric_q[$];
    int          n_clear_exp, cfg_issued, clr_got, cfg_got, p;

    reset_n = 1'b0;
    clear_done = 1'b0; config_done = 1'b0;
    metric_value = 8'h00; metric_send = 1'b0;
    output_fire_addr = 8'h00; output_fire_waiting = 1'b0;
    time_current = 32'h0; time_update = 1'b0;
    tx_rdy = 1'b0;

    tbl[0] = '{0, 32'h0,        0, 1, 48'h01_00_00_00_00_00, T_ACK};
    tbl[1] = '{1, 32'h0,        1, 1, 48'h02_00_00_00_00_00, -1};
    tbl[2] = '{2, 32'h7F,       0, 2, 48'h04_7F_00_00_00_00, -1};
    tbl[3] = '{2, 32'h00,       1, 2, 48'h04_00_00_00_00_00, -1};
    tbl[4] = '{3, 32'h2A,       0, 2, 48'h05_2A_00_00_00_00, T_FIRE};
    tbl[5] = '{3, 32'hFF,       2, 2, 48'h05_FF_00_00_00_00, T_FIRE};
    tbl[6] = '{4, 32'h01020304, 1, 5, 48'h03_01_02_03_04_00, T_TIME};
    tbl[7] = '{4, 32'hFFFFFFFF, 2, 5, 48'h03_FF_FF_FF_FF_00, T_TIME};
    tbl[8] = '{4, 32'h00000000, 0, 5, 48'h03_00_00_00_00_00, T_TIME};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset tx_vld", int'(tx_vld), 0);
    check("reset tx_data", int'(tx_data), 0);
    check("reset pulses", int'({ack_sent, metric_done, output_fire_sent, time_sent}), 0);
    check("reset busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Vector table: one packet per entry
    for (int v = 0; v < 9; v++) begin
      clear_logs();
      n_mdone = 0;
      auto_metric = 1'b1;
      rdy_mode = tbl[v].rdy;
      case (tbl[v].kind)
        0: clear_done = 1'b1;
        1: begin config_done = 1'b1; tick(); config_done = 1'b0; end
        2: begin metric_value = tbl[v].payload[7:0]; metric_send = 1'b1; end
        3: begin output_fire_addr = tbl[v].payload[7:0]; output_fire_waiting = 1'b1; end
        default: begin time_current = tbl[v].payload; time_update = 1'b1; end
      endcase
      run_until_idle($sformatf("vec%0d", v), 100);
      push_pkt(tbl[v].bytes, tbl[v].nbytes, tbl[v].pulse);
      compare_log($sformatf("vec%0d", v));
      if (tbl[v].kind == 2) check($sformatf("vec%0d metric_done pulses", v), n_mdone, 1);
    end
    check("stable tx_data under backpressure", stab_err, 0);

    // Latency from request to opcode, and payload snapshot ignoring later input changes
    clear_logs();
    rdy_mode = 3;
    output_fire_addr = 8'h2A;
    output_fire_waiting = 1'b1;
    tick();
    check("latency cycle1 tx_vld", int'(tx_vld), 0);
    tick();
    check("latency cycle2 tx_vld", int'(tx_vld), 1);
    check("latency cycle2 opcode", int'(tx_data), 8'h05);
    output_fire_addr = 8'h55;
    repeat (2) tick();
    rdy_mode = 0;
    run_until_idle("snapshot", 50);
    push_pkt(48'h05_2A_00_00_00_00, 2, T_FIRE);
    compare_log("snapshot");

    // Simultaneous clear, three config pulses and fire: priority order
    clear_logs();
    rdy_mode = 0;
    clear_done = 1'b1;
    output_fire_addr = 8'h33;
    output_fire_waiting = 1'b1;
    config_done = 1'b1;
    repeat (3) tick();
    config_done = 1'b0;
    run_until_idle("priority", 200);
    push_pkt(48'h01_00_00_00_00_00, 1, T_ACK);
    for (int i = 0; i < 3; i++) push_pkt(48'h02_00_00_00_00_00, 1, -1);
    push_pkt(48'h05_33_00_00_00_00, 2, T_FIRE);
    compare_log("priority");

    // Pending-config counter saturates at 15 while the link is stalled
    clear_logs();
    rdy_mode = 3;
    clear_done = 1'b1;
    repeat (2) tick();
    config_done = 1'b1;
    repeat (20) tick();
    config_done = 1'b0;
    rdy_mode = 0;
    run_until_idle("saturate", 400);
    push_pkt(48'h01_00_00_00_00_00, 1, T_ACK);
    for (int i = 0; i < 15; i++) push_pkt(48'h02_00_00_00_00_00, 1, -1);
    compare_log("saturate");

    // Level-held metric_send captured once; re-armed after it drops
    clear_logs();
    auto_metric = 1'b0;
    n_mdone = 0;
    metric_value = 8'h7F;
    metric_send = 1'b1;
    repeat (10) tick();
    metric_send = 1'b0;
    tick();
    run_until_idle("metric hold", 50);
    check("metric hold done pulses", n_mdone, 1);
    metric_value = 8'h11;
    metric_send = 1'b1;
    repeat (3) tick();
    metric_send = 1'b0;
    run_until_idle("metric rearm", 50);
    check("metric rearm done pulses", n_mdone, 2);
    push_pkt(48'h04_7F_00_00_00_00, 2, -1);
    push_pkt(48'h04_11_00_00_00_00, 2, -1);
    compare_log("metric");
    auto_metric = 1'b1;

    // Reset in the middle of a TIME packet
    clear_logs();
    rdy_mode = 0;
    time_current = 32'h01020304;
    time_update = 1'b1;
    for (int i = 0; i < 20 && log_q.size() < 2; i++) tick();
    check("midreset bytes before", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("midreset byte0", log_q[0], 8'h03);
      check("midreset byte1", log_q[1], 8'h01);
    end
    reset_n = 1'b0;
    #1;
    check("midreset tx_vld", int'(tx_vld), 0);
    check("midreset time_sent", int'(time_sent), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    clear_logs();
    run_until_idle("midreset restart", 50);
    push_pkt(48'h03_01_02_03_04_00, 5, T_TIME);
    compare_log("midreset restart");

    // Randomized traffic scored per packet type
    clear_logs();
    rdy_mode = 2;
    n_clear_exp = 0;
    cfg_issued = 0;
    cfg_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      config_done = 1'b0;
      if (!clear_done && $urandom_range(0, 24) == 0) begin
        clear_done = 1'b1;
        n_clear_exp++;
      end
      if ((cfg_issued - cfg_seen) < 10 && $urandom_range(0, 9) == 0) begin
        config_done = 1'b1;
        cfg_issued++;
      end
      if (!output_fire_waiting && $urandom_range(0, 5) == 0) begin
        output_fire_addr = 8'($urandom);
        output_fire_waiting = 1'b1;
        fire_q.push_back(32'(output_fire_addr));
      end
      if (!time_update && $urandom_range(0, 7) == 0) begin
        time_current = $urandom;
        time_update = 1'b1;
        time_q.push_back(time_current);
      end
      if (!metric_send && $urandom_range(0, 5) == 0) begin
        metric_value = 8'($urandom);
        metric_send = 1'b1;
        metric_q.push_back(32'(metric_value));
      end
      tick();
    end
    config_done = 1'b0;
    run_until_idle("random drain", 3000);

    clr_got = 0;
    cfg_got = 0;
    p = 0;
    while (p < log_q.size()) begin
      int          op, n;
      logic [7:0]  x;
      logic [31:0] val;
      op = log_q[p];
      check($sformatf("rand opcode valid at %0d", p), int'(op >= 1 && op <= 5), 1);
      n = pkt_len_of(op);
      if (p + n > log_q.size()) begin
        check("rand truncated packet", log_q.size(), p + n);
        break;
      end
      x = 8'h00;
      val = 32'h0;
      for (int k = 0; k < n - CHK; k++) begin
        x = x ^ 8'(log_q[p+k]);
        if (k > 0) val = {val[23:0], 8'(log_q[p+k])};
      end
      if (CHK != 0) check($sformatf("rand checksum at %0d", p), log_q[p+n-1], int'(x));
      p = p + n;
      case (op)
        1: begin
          clr_got++;
          check("rand ack after CLEAR", (p < log_q.size()) ? log_q[p] : -1, T_ACK);
          p++;
        end
        2: cfg_got++;
        4: begin
          check("rand metric expected", int'(metric_q.size() != 0), 1);
          if (metric_q.size() != 0) check("rand metric value", int'(val), int'(metric_q.pop_front()));
        end
        5: begin
          check("rand fire expected", int'(fire_q.size() != 0), 1);
          if (fire_q.size() != 0) check("rand fire addr", int'(val), int'(fire_q.pop_front()));
          check("rand fire sent after FIRE", (p < log_q.size()) ? log_q[p] : -1, T_FIRE);
          p++;
        end
        3: begin
          check("rand time expected", int'(time_q.size() != 0), 1);
          if (time_q.size() != 0) check("rand time value", int'(val), int'(time_q.pop_front()));
          check("rand time sent after TIME", (p < log_q.size()) ? log_q[p] : -1, T_TIME);
          p++;
        end
        default: ;
      endcase
    end
    check("rand clear packets", clr_got, n_clear_exp);
    check("rand cfg packets", cfg_got, cfg_issued);
    check("rand metric leftover", metric_q.size(), 0);
    check("rand fire leftover", fire_q.size(), 0);
    check("rand time leftover", time_q.size(), 0);
    check("rand stable tx_data", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
